// File: rtl/unidade_controle_if.sv
// unidade_controle_if: groups the control unit's datapath/memory signals.
//   master : control unit side (drives selects, enables and memory requests;
//            receives Instrucao, Zero and MemPronto)
//   slave  : datapath/memory side (the mirror image)
interface unidade_controle_if #(
    parameter int NUM_OPS = 3
);
    logic [15:0]        Instrucao;
    logic               Zero;
    logic               MemPronto;
    logic               MemLe;
    logic               MemEscreve;
    logic               SelEndMem;
    logic               EscreveIR;
    logic               EscrevePC;
    logic [1:0]         SelPC;
    logic               SelRegDestino;
    logic               SelULA_B;
    logic [NUM_OPS-1:0] OpULA;
    logic               SelDadoReg;
    logic               EscreveReg;
    logic               Parado;
    logic               Erro;

    modport master (
        input  Instrucao, Zero, MemPronto,
        output MemLe, MemEscreve, SelEndMem, EscreveIR, EscrevePC, SelPC,
               SelRegDestino, SelULA_B, OpULA, SelDadoReg, EscreveReg,
               Parado, Erro
    );

    modport slave (
        output Instrucao, Zero, MemPronto,
        input  MemLe, MemEscreve, SelEndMem, EscreveIR, EscrevePC, SelPC,
               SelRegDestino, SelULA_B, OpULA, SelDadoReg, EscreveReg,
               Parado, Erro
    );
endinterface

// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control FSM for the 8-bit processor.
// Sequences fetch, decode, execute, memory and write-back, drives every
// datapath select and owns all write enables.
//   Clock : rising-edge clock
//   Reset : synchronous, active-high; forces BUSCA and zeroes all outputs
//   ctrl  : unidade_controle_if.master (Instrucao/Zero/MemPronto in,
//           memory requests, selects, enables, Parado/Erro out)
module unidade_controle #(
    parameter int LARGURA_OP = 4,
    parameter int NUM_OPS    = 3
) (
    input logic                Clock,
    input logic                Reset,
    unidade_controle_if.master ctrl
);
    typedef enum logic [2:0] {
        BUSCA, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, PARADO
    } estado_t;

    localparam logic [LARGURA_OP-1:0] OP_NOP  = LARGURA_OP'(0);
    localparam logic [LARGURA_OP-1:0] OP_ADD  = LARGURA_OP'(1);
    localparam logic [LARGURA_OP-1:0] OP_SUB  = LARGURA_OP'(2);
    localparam logic [LARGURA_OP-1:0] OP_AND  = LARGURA_OP'(3);
    localparam logic [LARGURA_OP-1:0] OP_OR   = LARGURA_OP'(4);
    localparam logic [LARGURA_OP-1:0] OP_ADDI = LARGURA_OP'(5);
    localparam logic [LARGURA_OP-1:0] OP_LW   = LARGURA_OP'(6);
    localparam logic [LARGURA_OP-1:0] OP_SW   = LARGURA_OP'(7);
    localparam logic [LARGURA_OP-1:0] OP_BEQ  = LARGURA_OP'(8);
    localparam logic [LARGURA_OP-1:0] OP_JMP  = LARGURA_OP'(9);
    localparam logic [LARGURA_OP-1:0] OP_HALT = LARGURA_OP'(15);

    estado_t               estado, proximo;
    logic [LARGURA_OP-1:0] opcode_in, opcode_q;
    logic                  erro_q, erro_dec;

    logic                  mem_le, mem_escreve, sel_end_mem;
    logic                  escreve_ir, escreve_pc;
    logic [1:0]            sel_pc;
    logic                  sel_reg_destino, sel_ula_b;
    logic [NUM_OPS-1:0]    op_ula;
    logic                  sel_dado_reg, escreve_reg;

    // Only the opcode field matters here; register/immediate fields feed the datapath.
    logic unused_campos;
    assign unused_campos = ^ctrl.Instrucao[15-LARGURA_OP:0];
    assign opcode_in     = ctrl.Instrucao[15 -: LARGURA_OP];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado   <= BUSCA;
            opcode_q <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado <= proximo;
            // IR is stable only in DECODIFICA; later phases use this copy.
            if (estado == DECODIFICA) begin
                opcode_q <= opcode_in;
            end
            if (erro_dec) begin
                erro_q <= 1'b1;
            end
        end
    end

    always_comb begin
        proximo         = estado;
        mem_le          = 1'b0;
        mem_escreve     = 1'b0;
        sel_end_mem     = 1'b0;
        escreve_ir      = 1'b0;
        escreve_pc      = 1'b0;
        sel_pc          = 2'd0;
        sel_reg_destino = 1'b0;
        sel_ula_b       = 1'b0;
        op_ula          = '0;
        sel_dado_reg    = 1'b0;
        escreve_reg     = 1'b0;
        erro_dec        = 1'b0;

        case (estado)
            BUSCA: begin
                mem_le = 1'b1;
                if (ctrl.MemPronto) begin
                    escreve_ir = 1'b1;
                    escreve_pc = 1'b1;
                    proximo    = DECODIFICA;
                end
            end
            DECODIFICA: begin
                case (opcode_in)
                    OP_NOP: proximo = BUSCA;
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_ADDI, OP_LW, OP_SW, OP_BEQ: proximo = EXECUTA;
                    OP_JMP: begin
                        escreve_pc = 1'b1;
                        sel_pc     = 2'd2;
                        proximo    = BUSCA;
                    end
                    OP_HALT: proximo = PARADO;
                    default: begin
                        erro_dec = 1'b1;
                        proximo  = PARADO;
                    end
                endcase
            end
            EXECUTA: begin
                case (opcode_q)
                    OP_SUB, OP_BEQ: op_ula = NUM_OPS'(1);
                    OP_AND:         op_ula = NUM_OPS'(2);
                    OP_OR:          op_ula = NUM_OPS'(3);
                    default:        op_ula = NUM_OPS'(0);
                endcase
                sel_ula_b = (opcode_q == OP_ADDI) || (opcode_q == OP_LW) ||
                            (opcode_q == OP_SW);
                if (opcode_q == OP_BEQ) begin
                    if (ctrl.Zero) begin
                        escreve_pc = 1'b1;
                        sel_pc     = 2'd1;
                    end
                    proximo = BUSCA;
                end else if ((opcode_q == OP_LW) || (opcode_q == OP_SW)) begin
                    proximo = MEMORIA;
                end else begin
                    proximo = ESCRITA;
                end
            end
            MEMORIA: begin
                sel_end_mem = 1'b1;
                mem_le      = (opcode_q == OP_LW);
                mem_escreve = (opcode_q == OP_SW);
                if (ctrl.MemPronto) begin
                    proximo = (opcode_q == OP_LW) ? ESCRITA : BUSCA;
                end
            end
            ESCRITA: begin
                escreve_reg     = 1'b1;
                sel_reg_destino = (opcode_q == OP_ADDI) || (opcode_q == OP_LW);
                sel_dado_reg    = (opcode_q == OP_LW);
                proximo         = BUSCA;
            end
            PARADO:  proximo = PARADO;
            default: proximo = BUSCA;
        endcase
    end

    // Reset masks the decoded outputs so everything reads 0 while it is held.
    always_comb begin
        ctrl.MemLe         = !Reset && mem_le;
        ctrl.MemEscreve    = !Reset && mem_escreve;
        ctrl.SelEndMem     = !Reset && sel_end_mem;
        ctrl.EscreveIR     = !Reset && escreve_ir;
        ctrl.EscrevePC     = !Reset && escreve_pc;
        ctrl.SelPC         = Reset ? 2'd0 : sel_pc;
        ctrl.SelRegDestino = !Reset && sel_reg_destino;
        ctrl.SelULA_B      = !Reset && sel_ula_b;
        ctrl.OpULA         = Reset ? '0 : op_ula;
        ctrl.SelDadoReg    = !Reset && sel_dado_reg;
        ctrl.EscreveReg    = !Reset && escreve_reg;
        ctrl.Parado        = !Reset && (estado == PARADO);
        ctrl.Erro          = !Reset && (erro_q || erro_dec);
    end
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: self-checking bench for unidade_controle.
// A per-instruction phase model (fetch, decode, execute, memory, write-back)
// builds the expected cycle-by-cycle output sequence; tasks replay it with
// randomized memory delays, Zero values and don't-care inputs.
module tb_unidade_controle;
    typedef struct packed {
        logic       mem_le;
        logic       mem_escreve;
        logic       sel_end_mem;
        logic       escreve_ir;
        logic       escreve_pc;
        logic [1:0] sel_pc;
        logic       sel_reg_destino;
        logic       sel_ula_b;
        logic [2:0] op_ula;
        logic       sel_dado_reg;
        logic       escreve_reg;
        logic       parado;
        logic       erro;
    } saida_t;

    typedef struct packed {
        logic [15:0] instr;
        logic        mp;
        logic        z;
        saida_t      esp;
    } passo_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     comparacoes = 0;
    int     erros = 0;
    passo_t plano[$];
    saida_t obs;

    unidade_controle_if #(.NUM_OPS(3)) ctrl_if ();

    unidade_controle #(.LARGURA_OP(4), .NUM_OPS(3)) dut (
        .Clock (clk),
        .Reset (rst),
        .ctrl  (ctrl_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic saida_t amostra();
        saida_t s;
        s.mem_le          = ctrl_if.MemLe;
        s.mem_escreve     = ctrl_if.MemEscreve;
        s.sel_end_mem     = ctrl_if.SelEndMem;
        s.escreve_ir      = ctrl_if.EscreveIR;
        s.escreve_pc      = ctrl_if.EscrevePC;
        s.sel_pc          = ctrl_if.SelPC;
        s.sel_reg_destino = ctrl_if.SelRegDestino;
        s.sel_ula_b       = ctrl_if.SelULA_B;
        s.op_ula          = ctrl_if.OpULA;
        s.sel_dado_reg    = ctrl_if.SelDadoReg;
        s.escreve_reg     = ctrl_if.EscreveReg;
        s.parado          = ctrl_if.Parado;
        s.erro            = ctrl_if.Erro;
        return s;
    endfunction

    // Safety properties that must hold on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            logic pendente, viola;
            pendente = (ctrl_if.MemLe || ctrl_if.MemEscreve) && !ctrl_if.MemPronto;
            viola = (ctrl_if.MemLe && ctrl_if.MemEscreve) ||
                    (ctrl_if.EscreveReg && ctrl_if.EscrevePC) ||
                    (pendente && (ctrl_if.EscreveIR || ctrl_if.EscrevePC || ctrl_if.EscreveReg));
            comparacoes++;
            if (viola !== 1'b0) begin
                erros++;
                $display("FAIL invariante @%0t: got violation=%b required 0 (outputs %h)",
                         $time, viola, amostra());
            end
        end
    end

    // Drive one cycle's inputs just after a rising edge, sample mid-cycle.
    task automatic ciclo(input logic [15:0] instr, input logic mp, input logic z,
                         output saida_t o);
        ctrl_if.Instrucao = instr;
        ctrl_if.MemPronto = mp;
        ctrl_if.Zero      = z;
        @(negedge clk);
        o = amostra();
        @(posedge clk);
        #1;
    endtask

    task automatic empurra(input logic [15:0] i, input logic mp, input logic z,
                           input saida_t e);
        passo_t p;
        p.instr = i;
        p.mp    = mp;
        p.z     = z;
        p.esp   = e;
        plano.push_back(p);
    endtask

    // Reference model: expected per-cycle outputs for one instruction.
    task automatic planejar(input logic [15:0] instr, input int d_busca, input int d_mem,
                            input logic z, input int n_parado);
        int     op;
        logic   ilegal;
        saida_t e;
        op     = int'(instr[15:12]);
        ilegal = (op >= 10) && (op <= 14);
        for (int i = 0; i <= d_busca; i++) begin
            e = '0;
            e.mem_le = 1'b1;
            if (i == d_busca) begin
                e.escreve_ir = 1'b1;
                e.escreve_pc = 1'b1;
            end
            empurra(16'($urandom), i == d_busca, 1'($urandom), e);
        end
        e = '0;
        if (op == 9) begin
            e.escreve_pc = 1'b1;
            e.sel_pc     = 2'd2;
        end
        e.erro = ilegal;
        empurra(instr, 1'($urandom), 1'($urandom), e);
        if (op >= 1 && op <= 8) begin
            e = '0;
            case (op)
                2, 8:    e.op_ula = 3'd1;
                3:       e.op_ula = 3'd2;
                4:       e.op_ula = 3'd3;
                default: e.op_ula = 3'd0;
            endcase
            e.sel_ula_b = (op >= 5 && op <= 7);
            if (op == 8 && z) begin
                e.escreve_pc = 1'b1;
                e.sel_pc     = 2'd1;
            end
            empurra(16'($urandom), 1'($urandom), (op == 8) ? z : 1'($urandom), e);
        end
        if (op == 6 || op == 7) begin
            for (int i = 0; i <= d_mem; i++) begin
                e = '0;
                e.sel_end_mem = 1'b1;
                e.mem_le      = (op == 6);
                e.mem_escreve = (op == 7);
                empurra(16'($urandom), i == d_mem, 1'($urandom), e);
            end
        end
        if (op >= 1 && op <= 6) begin
            e = '0;
            e.escreve_reg     = 1'b1;
            e.sel_reg_destino = (op == 5 || op == 6);
            e.sel_dado_reg    = (op == 6);
            empurra(16'($urandom), 1'($urandom), 1'($urandom), e);
        end
        if (op == 15 || ilegal) begin
            for (int i = 0; i < n_parado; i++) begin
                e = '0;
                e.parado = 1'b1;
                e.erro   = ilegal;
                empurra(16'($urandom), 1'($urandom), 1'($urandom), e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ciclo(16'($urandom), 1'($urandom), 1'($urandom), obs);
            comparacoes++;
            if (obs !== saida_t'(0)) begin
                erros++;
                $display("FAIL reset[%0d]: got %h required %h", i, obs, saida_t'(0));
            end
        end
        rst = 1'b0;
        plano.delete();
        planejar(16'h1280, 0, 0, 1'b0, 0);
        planejar(16'h0000, 0, 0, 1'b0, 0);
        foreach (plano[k]) begin
            ciclo(plano[k].instr, plano[k].mp, plano[k].z, obs);
            comparacoes++;
            if (obs !== plano[k].esp) begin
                erros++;
                $display("FAIL add_apos_reset[%0d]: got %h required %h", k, obs, plano[k].esp);
            end
        end
    endtask

    task automatic test_lw();
        plano.delete();
        planejar(16'h6283, 0, 3, 1'b0, 0);
        planejar(16'h6283, 2, 0, 1'b0, 0);
        foreach (plano[k]) begin
            ciclo(plano[k].instr, plano[k].mp, plano[k].z, obs);
            comparacoes++;
            if (obs !== plano[k].esp) begin
                erros++;
                $display("FAIL lw[%0d]: got %h required %h", k, obs, plano[k].esp);
            end
        end
    endtask

    task automatic test_beq_jmp();
        plano.delete();
        planejar(16'h8040, 0, 0, 1'b1, 0);
        planejar(16'h8040, 0, 0, 1'b0, 0);
        planejar(16'h9005, 0, 0, 1'b0, 0);
        planejar(16'h9005, 1, 0, 1'b0, 0);
        planejar(16'h5123, 0, 0, 1'b0, 0);
        planejar(16'h7043, 1, 2, 1'b0, 0);
        foreach (plano[k]) begin
            ciclo(plano[k].instr, plano[k].mp, plano[k].z, obs);
            comparacoes++;
            if (obs !== plano[k].esp) begin
                erros++;
                $display("FAIL beq_jmp[%0d]: got %h required %h", k, obs, plano[k].esp);
            end
        end
    endtask

    task automatic test_parado();
        saida_t busca;
        busca = '0;
        busca.mem_le = 1'b1;
        for (int t = 0; t < 2; t++) begin
            plano.delete();
            planejar((t == 0) ? 16'hC000 : 16'hF000, 0, 0, 1'b0, 4);
            foreach (plano[k]) begin
                ciclo(plano[k].instr, plano[k].mp, plano[k].z, obs);
                comparacoes++;
                if (obs !== plano[k].esp) begin
                    erros++;
                    $display("FAIL parado%0d[%0d]: got %h required %h", t, k, obs, plano[k].esp);
                end
            end
            rst = 1'b1;
            ciclo(16'($urandom), 1'($urandom), 1'($urandom), obs);
            comparacoes++;
            if (obs !== saida_t'(0)) begin
                erros++;
                $display("FAIL parado%0d_reset: got %h required %h", t, obs, saida_t'(0));
            end
            rst = 1'b0;
            ciclo(16'($urandom), 1'b0, 1'($urandom), obs);
            comparacoes++;
            if (obs !== busca) begin
                erros++;
                $display("FAIL parado%0d_volta_busca: got %h required %h", t, obs, busca);
            end
        end
    endtask

    task automatic test_sw_reset();
        saida_t busca;
        busca = '0;
        busca.mem_le = 1'b1;
        plano.delete();
        planejar(16'h7043, 0, 6, 1'b0, 0);
        while (plano.size() > 5) void'(plano.pop_back());
        foreach (plano[k]) begin
            ciclo(plano[k].instr, plano[k].mp, plano[k].z, obs);
            comparacoes++;
            if (obs !== plano[k].esp) begin
                erros++;
                $display("FAIL sw_antes_reset[%0d]: got %h required %h", k, obs, plano[k].esp);
            end
        end
        rst = 1'b1;
        ciclo(16'($urandom), 1'b0, 1'($urandom), obs);
        comparacoes++;
        if (obs !== saida_t'(0)) begin
            erros++;
            $display("FAIL sw_reset: got %h required %h", obs, saida_t'(0));
        end
        rst = 1'b0;
        ciclo(16'($urandom), 1'b0, 1'($urandom), obs);
        comparacoes++;
        if (obs !== busca) begin
            erros++;
            $display("FAIL sw_apos_reset: got %h required %h", obs, busca);
        end
        plano.delete();
        planejar(16'h0000, 0, 0, 1'b0, 0);
        foreach (plano[k]) begin
            ciclo(plano[k].instr, plano[k].mp, plano[k].z, obs);
            comparacoes++;
            if (obs !== plano[k].esp) begin
                erros++;
                $display("FAIL sw_nop[%0d]: got %h required %h", k, obs, plano[k].esp);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 200; n++) begin
            int unsigned r;
            logic [3:0]  op;
            r  = $urandom_range(0, 21);
            op = (r <= 9) ? 4'(r) : (r <= 19) ? 4'($urandom_range(1, 8)) :
                 (r == 20) ? 4'hF : 4'($urandom_range(10, 14));
            plano.delete();
            planejar({op, 12'($urandom)}, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom), 2);
            foreach (plano[k]) begin
                ciclo(plano[k].instr, plano[k].mp, plano[k].z, obs);
                comparacoes++;
                if (obs !== plano[k].esp) begin
                    erros++;
                    $display("FAIL aleatorio[%0d.%0d] op=%h: got %h required %h",
                             n, k, op, obs, plano[k].esp);
                end
            end
            if (op == 4'hF || (op >= 4'hA && op <= 4'hE)) begin
                rst = 1'b1;
                ciclo(16'($urandom), 1'($urandom), 1'($urandom), obs);
                comparacoes++;
                if (obs !== saida_t'(0)) begin
                    erros++;
                    $display("FAIL aleatorio_reset[%0d]: got %h required %h", n, obs, saida_t'(0));
                end
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        ctrl_if.Instrucao = '0;
        ctrl_if.MemPronto = 1'b0;
        ctrl_if.Zero      = 1'b0;
        test_reset();
        test_lw();
        test_beq_jmp();
        test_parado();
        test_sw_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparacoes, erros);
        $finish;
    end
endmodule
